// File: rtl/dataformats_pkg.sv
// Shared MTC data-format constants used by the builder and its downstream blocks.
package dataformats_pkg;
  localparam int MTC2SL_LEN       = 16;
  localparam int MTC2SL_VALID_BIT = MTC2SL_LEN - 1;
endpackage

// File: rtl/mtc_lane_fifo.sv
// Per-lane synchronous FIFO; pointers carry one extra bit so full and empty differ by MSB.
module mtc_lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;

  // A push into a full FIFO is only legal alongside a pop; the slot being
  // overwritten is the one whose head is read out on the same edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign head  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);
endmodule

// File: rtl/mtc_out_arbiter.sv
// Buffers parallel MTC2SL lanes and round-robin serialises them onto one ready/valid link.
module mtc_out_arbiter #(
  parameter int MTC2SL_LEN    = dataformats_pkg::MTC2SL_LEN,
  parameter int n_PRIMARY_MTC = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0] mtc_in,
  output logic [MTC2SL_LEN-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CNT_WIDTH*n_PRIMARY_MTC-1:0] drop_count,
  output logic [n_PRIMARY_MTC-1:0]           lane_full,
  output logic                               idle
);
  localparam int N  = n_PRIMARY_MTC;
  localparam int L  = MTC2SL_LEN;
  localparam int VB = L - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][L-1:0]         lane_word;
  logic [N-1:0][L-1:0]         head;
  logic [N-1:0][AW:0]          count;
  logic [N-1:0]                empty, full, push, pop;
  logic [N-1:0][CNT_WIDTH-1:0] drop_cnt;
  logic [PW-1:0]               rr_ptr, grant;
  logic                        grant_vld, load;
  int                          idx;

  assign lane_word  = mtc_in;
  assign drop_count = drop_cnt;
  assign lane_full  = full;
  assign idle       = (&empty) && !out_valid;
  assign load       = !out_valid || out_ready;

  // First non-empty lane at or after rr_ptr, wrapping modulo N.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int j = 0; j < N; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= N) idx = idx - N;
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant     = PW'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_vld) pop[grant] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      // A full lane still accepts a word when it is being drained this edge.
      assign push[i] = lane_word[i][VB] &&
                       ((count[i] < (AW+1)'(FIFO_DEPTH)) || pop[i]);

      mtc_lane_fifo #(.WIDTH(L), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push[i]),
        .pop   (pop[i]),
        .din   (lane_word[i]),
        .head  (head[i]),
        .count (count[i]),
        .full  (full[i]),
        .empty (empty[i])
      );

      always_ff @(posedge clock) begin
        if (rst)
          drop_cnt[i] <= '0;
        else if (lane_word[i][VB] && !push[i] && !(&drop_cnt[i]))
          drop_cnt[i] <= drop_cnt[i] + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= grant_vld;
      out_data  <= grant_vld ? head[grant] : '0;
      if (grant_vld)
        rr_ptr <= (grant == PW'(N-1)) ? '0 : grant + 1'b1;
    end
  end
endmodule
